mor1kx_dpram_be_sclk: RTL and testbench

//  Single-clock RAM: one write port with byte enables, NUM_RD independent sync read ports.

---
 rtl/mor1kx_dpram_be_bank.sv | 47 ++++
 rtl/mor1kx_dpram_be_sclk.sv | 141 ++++++++++++++
 tb/tb_mor1kx_dpram_be_sclk.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mor1kx_dpram_be_bank.sv
// Single write port, single registered read port RAM with byte-lane write enables.
// A read during a write to the same address returns the old word.
module mor1kx_dpram_be_bank #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BYTE_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rd_clr,
  input  logic                             we,
  input  logic [ADDR_WIDTH-1:0]            waddr,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wbe,
  input  logic [DATA_WIDTH-1:0]            din,
  input  logic                             re,
  input  logic [ADDR_WIDTH-1:0]            raddr,
  output logic [DATA_WIDTH-1:0]            rdata
);

  localparam int unsigned BYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Byte-lane write; lanes with wbe low keep their contents.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (wbe[b]) begin
          mem[waddr][b*BYTE_WIDTH +: BYTE_WIDTH] <= din[b*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Registered read; rd_clr forces the output register to zero (reset or clearing).
  always_ff @(posedge clk) begin
    if (rd_clr) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mor1kx_dpram_be_sclk.sv
// Single-clock RAM: one byte-enable write port, NUM_RD synchronous read ports, optional
// per-byte write->read bypass and an optional post-reset clear sequencer.
module mor1kx_dpram_be_sclk #(
  parameter int unsigned ADDR_WIDTH     = 6,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BYTE_WIDTH     = 8,
  parameter int unsigned NUM_RD         = 2,
  parameter int unsigned ENABLE_BYPASS  = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]     raddr,
  input  logic [NUM_RD-1:0]                re,
  input  logic [ADDR_WIDTH-1:0]            waddr,
  input  logic                             we,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wbe,
  input  logic [DATA_WIDTH-1:0]            din,
  output logic [NUM_RD*DATA_WIDTH-1:0]     dout,
  output logic                             busy
);

  localparam int unsigned BYTES     = DATA_WIDTH / BYTE_WIDTH;
  localparam bit          BYPASS_EN = (ENABLE_BYPASS != 0);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  logic                  clr_active;
  logic [ADDR_WIDTH-1:0] clr_addr;

  if (CLEAR_ON_RESET != 0) begin : g_clear
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    // Clear sequencer state; reset (including mid-clear) restarts from address 0.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= ST_CLEAR;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // Walk every address once, leaving after the all-ones address is written.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
        ST_CLEAR: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          cnt_d = cnt_q;
        end
      endcase
    end

    assign clr_active = (state_q == ST_CLEAR);
    assign clr_addr   = cnt_q;
  end else begin : g_no_clear
    assign clr_active = 1'b0;
    assign clr_addr   = '0;
  end

  assign busy = clr_active;

  // External writes are dropped while clearing or in reset.
  logic                  ext_we;
  logic                  bank_we;
  logic [ADDR_WIDTH-1:0] bank_waddr;
  logic [BYTES-1:0]      bank_wbe;
  logic [DATA_WIDTH-1:0] bank_din;
  logic                  rd_clr;

  assign ext_we     = we & ~clr_active & ~rst;
  assign bank_we    = clr_active | ext_we;
  assign bank_waddr = clr_active ? clr_addr : waddr;
  assign bank_wbe   = clr_active ? {BYTES{1'b1}} : wbe;
  assign bank_din   = clr_active ? {DATA_WIDTH{1'b0}} : din;
  assign rd_clr     = rst | clr_active;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] raddr_i;
    logic [DATA_WIDTH-1:0] rdata;
    logic [BYTES-1:0]      mask_q;
    logic [DATA_WIDTH-1:0] din_r_q;
    logic [DATA_WIDTH-1:0] lane_mask;

    assign raddr_i = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];

    mor1kx_dpram_be_bank #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .BYTE_WIDTH (BYTE_WIDTH)
    ) u_bank (
      .clk    (clk),
      .rd_clr (rd_clr),
      .we     (bank_we),
      .waddr  (bank_waddr),
      .wbe    (bank_wbe),
      .din    (bank_din),
      .re     (re[i]),
      .raddr  (raddr_i),
      .rdata  (rdata)
    );

    // Capture the lanes written in the same cycle as a matching read; held while re is low.
    always_ff @(posedge clk) begin
      if (rd_clr) begin
        mask_q  <= '0;
        din_r_q <= '0;
      end else if (re[i]) begin
        if (BYPASS_EN && ext_we && (waddr == raddr_i)) begin
          mask_q  <= wbe;
          din_r_q <= din;
        end else begin
          mask_q  <= '0;
        end
      end
    end

    // Expand the per-byte mask to a per-bit mask.
    always_comb begin
      lane_mask = '0;
      for (int unsigned b = 0; b < BYTES; b++) begin
        lane_mask[b*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{mask_q[b]}};
      end
    end

    assign dout[i*DATA_WIDTH +: DATA_WIDTH] = (din_r_q & lane_mask) | (rdata & ~lane_mask);
  end

endmodule

// File: tb/tb_mor1kx_dpram_be_sclk.sv
// Bench for mor1kx_dpram_be_sclk: one instance with bypass, one without, sharing stimulus,
// both compared against a word-level memory model.
module tb_mor1kx_dpram_be_sclk;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int NR = 2;
  localparam int DEPTH = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR*AW-1:0] raddr = '0;
  logic [NR-1:0]   re = '0;
  logic [AW-1:0]   waddr = '0;
  logic            we = 1'b0;
  logic [3:0]      wbe = '0;
  logic [DW-1:0]   din = '0;
  logic [NR*DW-1:0] dout_a, dout_b;
  logic            busy_a, busy_b;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] exp_a [NR];
  logic [DW-1:0] exp_b [NR];
  int            clr_left = 0;

  always #5 clk = ~clk;

  mor1kx_dpram_be_sclk #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .BYTE_WIDTH (8), .NUM_RD (NR),
    .ENABLE_BYPASS (1), .CLEAR_ON_RESET (1)
  ) dut (
    .clk (clk), .rst (rst), .raddr (raddr), .re (re), .waddr (waddr), .we (we),
    .wbe (wbe), .din (din), .dout (dout_a), .busy (busy_a)
  );

  mor1kx_dpram_be_sclk #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .BYTE_WIDTH (8), .NUM_RD (NR),
    .ENABLE_BYPASS (0), .CLEAR_ON_RESET (1)
  ) dut_nb (
    .clk (clk), .rst (rst), .raddr (raddr), .re (re), .waddr (waddr), .we (we),
    .wbe (wbe), .din (din), .dout (dout_b), .busy (busy_b)
  );

  // Advance one clock, update the model from the inputs seen at that edge, sample at +1.
  task automatic cycle();
    logic [DW-1:0] old_w, new_w;
    int ra;
    @(posedge clk);
    if (rst) begin
      clr_left = DEPTH;
      for (int i = 0; i < NR; i++) begin exp_a[i] = '0; exp_b[i] = '0; end
    end else if (clr_left > 0) begin
      mem_m[DEPTH - clr_left] = '0;
      clr_left--;
      for (int i = 0; i < NR; i++) begin exp_a[i] = '0; exp_b[i] = '0; end
    end else begin
      new_w = mem_m[waddr];
      for (int b = 0; b < 4; b++) if (wbe[b]) new_w[b*8 +: 8] = din[b*8 +: 8];
      for (int i = 0; i < NR; i++) begin
        if (re[i]) begin
          ra = int'(raddr[i*AW +: AW]);
          old_w = mem_m[ra];
          exp_b[i] = old_w;
          exp_a[i] = (we && ra == int'(waddr)) ? new_w : old_w;
        end
      end
      if (we) mem_m[waddr] = new_w;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      checks++;
      if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
        errors++;
        $display("FAIL reset_busy k=%0d got %b/%b want 1", k, busy_a, busy_b);
      end
      checks++;
      if (dout_a !== '0 || dout_b !== '0) begin
        errors++;
        $display("FAIL reset_dout k=%0d got %h/%h want 0", k, dout_a, dout_b);
      end
      cycle();
    end
    checks++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy_end got %b/%b want 0", busy_a, busy_b);
    end
    re = 2'b11;
    for (int a = 0; a < DEPTH; a++) begin
      raddr = {4'(DEPTH - 1 - a), 4'(a)};
      cycle();
      checks++;
      if (dout_a !== '0 || dout_b !== '0) begin
        errors++;
        $display("FAIL reset_clear addr=%0d got %h/%h want 0", a, dout_a, dout_b);
      end
    end
    re = '0;
  endtask

  task automatic test_write_read();
    we = 1'b1; waddr = 4'd3; wbe = 4'hF; din = 32'hDEADBEEF;
    cycle();
    we = 1'b0; re = 2'b01; raddr = {4'd0, 4'd3};
    cycle();
    re = 2'b00; raddr = {4'd9, 4'd7};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (dout_a[31:0] !== 32'hDEADBEEF || dout_b[31:0] !== 32'hDEADBEEF) begin
        errors++;
        $display("FAIL write_read k=%0d got %h/%h want deadbeef", k, dout_a[31:0],
                 dout_b[31:0]);
      end
      cycle();
    end
  endtask

  task automatic test_bypass();
    we = 1'b1; waddr = 4'd5; wbe = 4'hF; din = 32'h11223344;
    cycle();
    wbe = 4'b0011; din = 32'hAABBCCDD; re = 2'b10; raddr = {4'd5, 4'd0};
    cycle();
    we = 1'b0;
    checks++;
    if (dout_a[63:32] !== 32'h1122CCDD) begin
      errors++;
      $display("FAIL bypass_first got %h want 1122ccdd", dout_a[63:32]);
    end
    checks++;
    if (dout_b[63:32] !== 32'h11223344) begin
      errors++;
      $display("FAIL nobypass_first got %h want 11223344", dout_b[63:32]);
    end
    checks++;
    if (dout_a[31:0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL bypass_hold_p0 got %h want deadbeef", dout_a[31:0]);
    end
    cycle();
    re = 2'b00;
    checks++;
    if (dout_a[63:32] !== 32'h1122CCDD || dout_b[63:32] !== 32'h1122CCDD) begin
      errors++;
      $display("FAIL bypass_reread got %h/%h want 1122ccdd", dout_a[63:32], dout_b[63:32]);
    end
  endtask

  task automatic test_clear_restart();
    we = 1'b1; waddr = 4'd2; wbe = 4'hF; din = 32'h12345678;
    cycle();
    we = 1'b0; rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (7) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    we = 1'b1; waddr = 4'd2; wbe = 4'hF; din = 32'hFFFFFFFF;
    re = 2'b11; raddr = {4'd2, 4'd2};
    for (int k = 0; k < DEPTH; k++) begin
      checks++;
      if (busy_a !== 1'b1 || dout_a !== '0 || dout_b !== '0) begin
        errors++;
        $display("FAIL restart_busy k=%0d got busy=%b dout=%h/%h want 1,0", k, busy_a,
                 dout_a, dout_b);
      end
      cycle();
    end
    checks++;
    if (busy_a !== 1'b0 || dout_a !== '0) begin
      errors++;
      $display("FAIL restart_last_read got busy=%b dout=%h want 0,0", busy_a, dout_a);
    end
    we = 1'b0;
    cycle();
    re = 2'b00;
    checks++;
    if (dout_a !== '0 || dout_b !== '0) begin
      errors++;
      $display("FAIL restart_mem2 got %h/%h want 0", dout_a, dout_b);
    end
  endtask

  task automatic test_concurrent();
    we = 1'b1; wbe = 4'hF;
    waddr = 4'd1; din = 32'h55555555;
    cycle();
    waddr = 4'd3; din = 32'hCAFE1234;
    cycle();
    waddr = 4'd1; din = 32'h0BADF00D; re = 2'b11; raddr = {4'd3, 4'd1};
    cycle();
    we = 1'b0;
    checks++;
    if (dout_a !== {32'hCAFE1234, 32'h0BADF00D}) begin
      errors++;
      $display("FAIL concurrent_bypass got %h want cafe1234_0badf00d", dout_a);
    end
    checks++;
    if (dout_b !== {32'hCAFE1234, 32'h55555555}) begin
      errors++;
      $display("FAIL concurrent_nobypass got %h want cafe1234_55555555", dout_b);
    end
    cycle();
    re = 2'b00;
    checks++;
    if (dout_b[31:0] !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL concurrent_reread got %h want 0badf00d", dout_b[31:0]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rst   = ($urandom_range(0, 199) == 0);
      we    = $urandom_range(0, 1) == 1;
      waddr = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      wbe   = 4'($urandom);
      din   = $urandom;
      re    = 2'($urandom);
      for (int i = 0; i < NR; i++)
        raddr[i*AW +: AW] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3))
                                                          : 4'($urandom);
      cycle();
      checks++;
      if (busy_a !== (clr_left > 0) || busy_b !== (clr_left > 0)) begin
        errors++;
        $display("FAIL rand_busy n=%0d got %b/%b want %b", n, busy_a, busy_b, clr_left > 0);
      end
      for (int i = 0; i < NR; i++) begin
        checks++;
        if (dout_a[i*DW +: DW] !== exp_a[i] || dout_b[i*DW +: DW] !== exp_b[i]) begin
          errors++;
          $display("FAIL rand_dout n=%0d port=%0d got %h/%h want %h/%h", n, i,
                   dout_a[i*DW +: DW], dout_b[i*DW +: DW], exp_a[i], exp_b[i]);
        end
      end
    end
    rst = 1'b0; we = 1'b0; re = '0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_clear_restart();
    test_concurrent();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
